adrv9009_rsp: RTL and testbench

//  Receive-signal-path (RSP) low-pass filter chain for one ADRV9009 real data lane.
//  - Accepts one signed 16-bit sample per clk and produces one filtered sample per clk; no decimation.
//  - Chain: two identical half-band FIRs (HB1, HB2), then a 4-tap moving-average stage (MA4).
//  - MA4 nulls fs/4 and fs/2.
//  - Sits between the ADC sample interface and downstream baseband processing.

---
 rtl/rsp_pkg.sv | 34 +++
 rtl/rsp_hb_fir.sv | 36 +++
 rtl/adrv9009_rsp.sv | 62 ++++++
 tb/tb_adrv9009_rsp.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/rsp_pkg.sv
// Shared constants and arithmetic helpers for the ADRV9009 receive-signal-path filter chain.
package rsp_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ACC_W    = 24;
    localparam int unsigned HB_TAPS  = 7;
    localparam int unsigned HB_SHIFT = 5;
    localparam int unsigned MA_TAPS  = 4;
    localparam int unsigned MA_SHIFT = 2;

    localparam int HB_COEF [0:HB_TAPS-1] = '{-1, 0, 9, 16, 9, 0, -1};

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    // Round half up, then arithmetic shift right by s
    function automatic logic signed [ACC_W-1:0] rnd(input logic signed [ACC_W-1:0] a,
                                                     input int unsigned s);
        logic signed [ACC_W-1:0] half;
        half = ACC_W'(1) <<< (s - 1);
        return (a + half) >>> s;
    endfunction

    // Clamp an accumulator value to the signed 16-bit range
    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX) begin
            return DATA_W'(32767);
        end else if (a < SAT_MIN) begin
            return DATA_W'(-32768);
        end
        return DATA_W'(a);
    endfunction

endpackage

// File: rtl/rsp_hb_fir.sv
// 7-tap symmetric half-band FIR with registered, rounded and saturated output.
module rsp_hb_fir
    import rsp_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y
);

    logic signed [DATA_W-1:0] dly [1:HB_TAPS-1];
    logic signed [ACC_W-1:0]  acc_c;

    // Symmetric taps are pre-added; the zero taps at offsets 1 and 5 are dropped
    always_comb begin
        acc_c = ACC_W'(HB_COEF[0]) * (ACC_W'(x)      + ACC_W'(dly[6]))
              + ACC_W'(HB_COEF[2]) * (ACC_W'(dly[2]) + ACC_W'(dly[4]))
              + ACC_W'(HB_COEF[3]) *  ACC_W'(dly[3]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y <= '0;
            for (int k = 1; k < int'(HB_TAPS); k++) begin
                dly[k] <= '0;
            end
        end else begin
            y      <= sat16(rnd(acc_c, HB_SHIFT));
            dly[1] <= x;
            for (int k = 2; k < int'(HB_TAPS); k++) begin
                dly[k] <= dly[k-1];
            end
        end
    end

endmodule

// File: rtl/adrv9009_rsp.sv
// Receive-signal-path low-pass chain: input register, two half-band FIRs, 4-tap moving average.
module adrv9009_rsp
    import rsp_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in,
    output logic signed [DATA_W-1:0] out
);

    logic signed [DATA_W-1:0] in_r;
    logic signed [DATA_W-1:0] hb1_y;
    logic signed [DATA_W-1:0] hb2_y;
    logic signed [DATA_W-1:0] ma_dly [1:MA_TAPS-1];
    logic signed [ACC_W-1:0]  ma_acc_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_r <= '0;
        end else begin
            in_r <= in;
        end
    end

    rsp_hb_fir u_hb1 (
        .clk   (clk),
        .reset (reset),
        .x     (in_r),
        .y     (hb1_y)
    );

    rsp_hb_fir u_hb2 (
        .clk   (clk),
        .reset (reset),
        .x     (hb1_y),
        .y     (hb2_y)
    );

    // Moving average over the current HB2 output and its three predecessors
    always_comb begin
        ma_acc_c = ACC_W'(hb2_y);
        for (int k = 1; k < int'(MA_TAPS); k++) begin
            ma_acc_c = ma_acc_c + ACC_W'(ma_dly[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
            for (int k = 1; k < int'(MA_TAPS); k++) begin
                ma_dly[k] <= '0;
            end
        end else begin
            out       <= sat16(rnd(ma_acc_c, MA_SHIFT));
            ma_dly[1] <= hb2_y;
            for (int k = 2; k < int'(MA_TAPS); k++) begin
                ma_dly[k] <= ma_dly[k-1];
            end
        end
    end

endmodule

// File: tb/tb_adrv9009_rsp.sv
// Self-checking bench for adrv9009_rsp against a sequence-level convolution model.
module tb_adrv9009_rsp;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] in;
    logic signed [15:0] out;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state: recent sample history seen by each stage, newest first
    int hb_h [7] = '{-1, 0, 9, 16, 9, 0, -1};
    int s0_h [7];
    int s1_h [7];
    int s2_h [4];
    int out_m;
    int cur;

    int lv    [8] = '{0, 23170, 32767, 23170, 0, -23170, -32768, -23170};
    int fs4_v [4] = '{0, 32767, 0, -32768};

    always #5 clk = ~clk;

    adrv9009_rsp dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (out)
    );

    function automatic int rnd_m(input int a, input int s);
        return (a + (1 << (s - 1))) >>> s;
    endfunction

    function automatic int sat_m(input int a);
        if (a > 32767)  return 32767;
        if (a < -32768) return -32768;
        return a;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model_edge(input int v, input logic r);
        int a1, a2, a3, n1, n2;
        if (r) begin
            for (int k = 0; k < 7; k++) begin
                s0_h[k] = 0;
                s1_h[k] = 0;
            end
            for (int k = 0; k < 4; k++) s2_h[k] = 0;
            out_m = 0;
        end else begin
            a1 = 0; a2 = 0; a3 = 0;
            for (int k = 0; k < 7; k++) begin
                a1 += hb_h[k] * s0_h[k];
                a2 += hb_h[k] * s1_h[k];
            end
            for (int k = 0; k < 4; k++) a3 += s2_h[k];
            n1    = sat_m(rnd_m(a1, 5));
            n2    = sat_m(rnd_m(a2, 5));
            out_m = sat_m(rnd_m(a3, 2));
            for (int k = 6; k > 0; k--) begin
                s0_h[k] = s0_h[k-1];
                s1_h[k] = s1_h[k-1];
            end
            for (int k = 3; k > 0; k--) s2_h[k] = s2_h[k-1];
            s0_h[0] = v;
            s1_h[0] = n1;
            s2_h[0] = n2;
        end
    endtask

    // One clock: drive, let the edge happen, update model, compare on falling edge
    task automatic step(input int v, input logic r);
        in    = 16'(v);
        reset = r;
        @(posedge clk);
        model_edge(v, r);
        @(negedge clk);
        cur = int'(out);
        check("model", cur, out_m);
    endtask

    function automatic int rand_s16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    initial begin
        int sum, mx, mn;
        reset = 1'b1;
        in    = '0;
        for (int k = 0; k < 7; k++) begin
            s0_h[k] = 0;
            s1_h[k] = 0;
        end
        for (int k = 0; k < 4; k++) s2_h[k] = 0;
        out_m = 0;
        @(negedge clk);

        for (int i = 0; i < 55; i++) begin
            step(rand_s16(), 1'b1);
            check("reset_hold", cur, 0);
        end
        step(rand_s16(), 1'b0);
        check("reset_release", cur, 0);

        for (int i = 0; i < 25; i++) step(0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            step(16384, 1'b0);
            if (i >= 19) check("dc_settled", cur, 16384);
        end

        for (int i = 0; i < 25; i++) step(0, 1'b0);
        sum = 0;
        for (int i = 1; i <= 30; i++) begin
            step((i == 1) ? 32 : 0, 1'b0);
            sum += cur;
            if (i <= 3)  check("imp_early", cur, 0);
            if (i >= 19) check("imp_tail", cur, 0);
        end
        check("imp_sum_in_28_36", int'(sum >= 28 && sum <= 36), 1);

        mx = -40000; mn = 40000;
        for (int p = 0; p < 5; p++)
            for (int l = 0; l < 8; l++)
                for (int h = 0; h < 25; h++) begin
                    step(lv[l], 1'b0);
                    if (cur > mx) mx = cur;
                    if (cur < mn) mn = cur;
                end
        check("slow_peak_pos", int'(mx >= 31784), 1);
        check("slow_peak_neg", int'(mn <= -31785), 1);

        mx = -40000; mn = 40000;
        for (int p = 0; p < 10; p++)
            for (int l = 0; l < 8; l++)
                for (int h = 0; h < 10; h++) begin
                    step(lv[l], 1'b0);
                    if (p > 0 && cur > mx) mx = cur;
                    if (p > 0 && cur < mn) mn = cur;
                end
        check("mid_peak_pos", int'(mx >= 29491), 1);
        check("mid_peak_neg", int'(mn <= -29491), 1);

        for (int i = 0; i < 100; i++) begin
            step(fs4_v[i % 4], 1'b0);
            if (i >= 30) check("fs4_null", int'(cur <= 2 && cur >= -2), 1);
        end

        for (int i = 0; i < 40; i++) step(lv[(i / 10) % 8], 1'b0);
        step(lv[4], 1'b1);
        check("mid_reset", cur, 0);
        for (int i = 0; i < 3; i++) begin
            step(lv[(i + 40) / 10 % 8], 1'b0);
            check("post_reset_empty", cur, 0);
        end
        for (int i = 0; i < 40; i++) step(lv[(i / 10 + 4) % 8], 1'b0);

        for (int i = 0; i < 400; i++) begin
            step(rand_s16(), 1'b0 || ($urandom_range(49) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
